// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS control unit: opcodes, functs, ALU selects, FSM states.
// Funct 000100 (sllv) is honoured only when MIPS_SLLV_EN is defined.
package mips_ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FN_ADD  = 6'b100000;
  localparam logic [5:0] FN_SUB  = 6'b100010;
  localparam logic [5:0] FN_AND  = 6'b100100;
  localparam logic [5:0] FN_OR   = 6'b100101;
  localparam logic [5:0] FN_SLT  = 6'b101010;
  localparam logic [5:0] FN_SLLV = 6'b000100;

  localparam logic [2:0] ALU_ADD  = 3'b010;
  localparam logic [2:0] ALU_SUB  = 3'b110;
  localparam logic [2:0] ALU_AND  = 3'b000;
  localparam logic [2:0] ALU_OR   = 3'b001;
  localparam logic [2:0] ALU_SLT  = 3'b111;
  localparam logic [2:0] ALU_LUI  = 3'b100;
  localparam logic [2:0] ALU_SLLV = 3'b011;

  typedef enum logic [1:0] {
    AOP_ADD   = 2'b00,
    AOP_SUB   = 2'b01,
    AOP_FUNCT = 2'b10,
    AOP_LUI   = 2'b11
  } alu_op_e;

  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_MEM_ADR   = 4'd2,
    S_MEM_READ  = 4'd3,
    S_MEM_WB    = 4'd4,
    S_MEM_WRITE = 4'd5,
    S_EXECUTE   = 4'd6,
    S_ALU_WB    = 4'd7,
    S_BRANCH    = 4'd8,
    S_IMM_EXEC  = 4'd9,
    S_IMM_WB    = 4'd10,
    S_JUMP      = 4'd11
  } state_e;

endpackage

// File: rtl/multicycle_control_unit_alu_sel_decoder.sv
// Combinational ALU select decode from a 2-bit ALU_Op plus the R-type funct field.
// MIPS_SLLV_EN adds funct 000100 -> sllv; otherwise that funct is reported invalid.
module alu_sel_decoder
  import mips_ctrl_pkg::*;
#(
  parameter int SEL = 3,
  parameter int OPW = 6
) (
  input  logic [1:0]     ALU_Op,
  input  logic [OPW-1:0] Funct,
  output logic [SEL-1:0] ALU_Sel,
  output logic           Funct_Valid
);

  logic [2:0] sel;

  always_comb begin
    sel         = ALU_ADD;
    Funct_Valid = 1'b1;
    case (ALU_Op)
      AOP_ADD: sel = ALU_ADD;
      AOP_SUB: sel = ALU_SUB;
      AOP_LUI: sel = ALU_LUI;
      default: begin
        case (Funct)
          FN_ADD:  sel = ALU_ADD;
          FN_SUB:  sel = ALU_SUB;
          FN_AND:  sel = ALU_AND;
          FN_OR:   sel = ALU_OR;
          FN_SLT:  sel = ALU_SLT;
`ifdef MIPS_SLLV_EN
          FN_SLLV: sel = ALU_SLLV;
`endif
          // Unknown funct: keep the ALU on a harmless add and flag it.
          default: begin
            sel         = ALU_ADD;
            Funct_Valid = 1'b0;
          end
        endcase
      end
    endcase
  end

  assign ALU_Sel = SEL'(sel);

endmodule

// File: rtl/multicycle_control_unit.sv
// Multicycle MIPS control FSM: Moore decode of the state register, Mealy PC_En in BRANCH.
// Optional sllv support via MIPS_SLLV_EN (handled in alu_sel_decoder).
module multicycle_control_unit
  import mips_ctrl_pkg::*;
#(
  parameter int SEL = 3,
  parameter int OPW = 6
) (
  input  logic           CLK,
  input  logic           RST,
  input  logic [OPW-1:0] Opcode,
  input  logic [OPW-1:0] Funct,
  input  logic           ALU_Zero_Flag,
  output logic           PC_En,
  output logic           IorD,
  output logic           Mem_Write,
  output logic           IR_Write,
  output logic           Reg_Dst,
  output logic           Mem_To_Reg,
  output logic           Reg_Write,
  output logic           ALU_Src_A,
  output logic [1:0]     ALU_Src_B,
  output logic [1:0]     PC_Src,
  output logic [SEL-1:0] ALU_Sel,
  output logic           Illegal_Op,
  output logic [3:0]     State
);

  state_e  state_q, state_d;
  alu_op_e alu_op;
  logic    funct_ok;
  logic    pc_write, branch, mem_wr, ir_wr, reg_wr, illegal;

  alu_sel_decoder #(.SEL(SEL), .OPW(OPW)) u_alu_sel_decoder (
    .ALU_Op      (alu_op),
    .Funct       (Funct),
    .ALU_Sel     (ALU_Sel),
    .Funct_Valid (funct_ok)
  );

  always_comb begin
    state_d    = S_FETCH;
    pc_write   = 1'b0;
    branch     = 1'b0;
    mem_wr     = 1'b0;
    ir_wr      = 1'b0;
    reg_wr     = 1'b0;
    illegal    = 1'b0;
    IorD       = 1'b0;
    Reg_Dst    = 1'b0;
    Mem_To_Reg = 1'b0;
    ALU_Src_A  = 1'b0;
    ALU_Src_B  = 2'b00;
    PC_Src     = 2'b00;
    alu_op     = AOP_ADD;
    case (state_q)
      S_FETCH: begin
        ir_wr     = 1'b1;
        ALU_Src_B = 2'b01;
        pc_write  = 1'b1;
        state_d   = S_DECODE;
      end
      S_DECODE: begin
        ALU_Src_B = 2'b11;
        case (Opcode)
          OP_LW, OP_SW:    state_d = S_MEM_ADR;
          OP_RTYPE:        state_d = S_EXECUTE;
          OP_BEQ:          state_d = S_BRANCH;
          OP_ADDI, OP_LUI: state_d = S_IMM_EXEC;
          OP_J:            state_d = S_JUMP;
          default:         illegal = 1'b1;
        endcase
      end
      S_MEM_ADR: begin
        ALU_Src_A = 1'b1;
        ALU_Src_B = 2'b10;
        state_d   = (Opcode == OP_SW) ? S_MEM_WRITE : S_MEM_READ;
      end
      S_MEM_READ: begin
        IorD    = 1'b1;
        state_d = S_MEM_WB;
      end
      S_MEM_WB: begin
        Mem_To_Reg = 1'b1;
        reg_wr     = 1'b1;
      end
      S_MEM_WRITE: begin
        IorD   = 1'b1;
        mem_wr = 1'b1;
      end
      S_EXECUTE: begin
        ALU_Src_A = 1'b1;
        alu_op    = AOP_FUNCT;
        if (funct_ok) state_d = S_ALU_WB;
        else          illegal = 1'b1;
      end
      S_ALU_WB: begin
        Reg_Dst = 1'b1;
        reg_wr  = 1'b1;
      end
      S_BRANCH: begin
        ALU_Src_A = 1'b1;
        alu_op    = AOP_SUB;
        branch    = 1'b1;
        PC_Src    = 2'b01;
      end
      S_IMM_EXEC: begin
        ALU_Src_A = 1'b1;
        ALU_Src_B = 2'b10;
        alu_op    = (Opcode == OP_LUI) ? AOP_LUI : AOP_ADD;
        state_d   = S_IMM_WB;
      end
      S_IMM_WB: reg_wr = 1'b1;
      S_JUMP: begin
        PC_Src   = 2'b10;
        pc_write = 1'b1;
      end
      default: state_d = S_FETCH;
    endcase
  end

  // Enables are masked by RST combinationally so nothing writes during reset,
  // including the cycle in which RST first rises mid-instruction.
  assign PC_En      = ~RST & (pc_write | (branch & ALU_Zero_Flag));
  assign Mem_Write  = ~RST & mem_wr;
  assign IR_Write   = ~RST & ir_wr;
  assign Reg_Write  = ~RST & reg_wr;
  assign Illegal_Op = ~RST & illegal;
  assign State      = state_q;

  always_ff @(posedge CLK) begin
    if (RST) state_q <= S_FETCH;
    else     state_q <= state_d;
  end

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Directed bench for multicycle_control_unit; funct 000100 expectations follow MIPS_SLLV_EN.
module tb_multicycle_control_unit;

  logic       CLK = 1'b0;
  logic       RST;
  logic [5:0] Opcode, Funct;
  logic       ALU_Zero_Flag;
  logic       PC_En, IorD, Mem_Write, IR_Write, Reg_Dst, Mem_To_Reg, Reg_Write, ALU_Src_A;
  logic [1:0] ALU_Src_B, PC_Src;
  logic [2:0] ALU_Sel;
  logic       Illegal_Op;
  logic [3:0] State;

  int unsigned total = 0;
  int unsigned bad   = 0;

  multicycle_control_unit #(.SEL(3), .OPW(6)) dut (
    .CLK(CLK), .RST(RST), .Opcode(Opcode), .Funct(Funct), .ALU_Zero_Flag(ALU_Zero_Flag),
    .PC_En(PC_En), .IorD(IorD), .Mem_Write(Mem_Write), .IR_Write(IR_Write),
    .Reg_Dst(Reg_Dst), .Mem_To_Reg(Mem_To_Reg), .Reg_Write(Reg_Write),
    .ALU_Src_A(ALU_Src_A), .ALU_Src_B(ALU_Src_B), .PC_Src(PC_Src),
    .ALU_Sel(ALU_Sel), .Illegal_Op(Illegal_Op), .State(State)
  );

  always #5 CLK = ~CLK;

  // Check all outputs at the negedge of the current cycle, then move to just after the next posedge.
  task automatic exp(input string tag, input logic [3:0] st, input logic pcen, iord, mw, irw,
                     rdst, m2r, rw, sa, input logic [1:0] sb, ps, input logic [2:0] sel,
                     input logic ill);
    logic [19:0] o, e;
    @(negedge CLK);
    o = {State, PC_En, IorD, Mem_Write, IR_Write, Reg_Dst, Mem_To_Reg, Reg_Write, ALU_Src_A,
         ALU_Src_B, PC_Src, ALU_Sel, Illegal_Op};
    e = {st, pcen, iord, mw, irw, rdst, m2r, rw, sa, sb, ps, sel, ill};
    total++;
    assert (o === e) else begin
      bad++;
      $error("FAIL %s observed=%05h expected=%05h", tag, o, e);
    end
    @(posedge CLK);
    #1;
  endtask

  task automatic fetch(input string tag);
    exp(tag, 4'd0, 1,0,0,1,0,0,0,0, 2'b01, 2'b00, 3'b010, 0);
  endtask

  task automatic decode(input string tag, input logic ill);
    exp(tag, 4'd1, 0,0,0,0,0,0,0,0, 2'b11, 2'b00, 3'b010, ill);
  endtask

  task automatic start(input logic [5:0] op, input logic [5:0] fn);
    Opcode = op;
    Funct  = fn;
  endtask

  logic [5:0] fn_tab  [4] = '{6'b100000, 6'b100100, 6'b100101, 6'b101010};
  logic [2:0] sel_tab [4] = '{3'b010,    3'b000,    3'b001,    3'b111};

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    RST = 1'b1; Opcode = '0; Funct = '0; ALU_Zero_Flag = 1'b0;
    @(posedge CLK);
    #1;
    for (int i = 0; i < 3; i++)
      exp("reset_hold", 4'd0, 0,0,0,0,0,0,0,0, 2'b01, 2'b00, 3'b010, 0);
    RST = 1'b0;

    // lw: 0,1,2,3,4
    start(6'b100011, 6'b000000);
    fetch("lw_fetch");
    decode("lw_decode", 0);
    exp("lw_memadr", 4'd2, 0,0,0,0,0,0,0,1, 2'b10, 2'b00, 3'b010, 0);
    exp("lw_memrd",  4'd3, 0,1,0,0,0,0,0,0, 2'b00, 2'b00, 3'b010, 0);
    exp("lw_memwb",  4'd4, 0,0,0,0,0,1,1,0, 2'b00, 2'b00, 3'b010, 0);

    // sw: 0,1,2,5
    start(6'b101011, 6'b000000);
    fetch("sw_fetch");
    decode("sw_decode", 0);
    exp("sw_memadr", 4'd2, 0,0,0,0,0,0,0,1, 2'b10, 2'b00, 3'b010, 0);
    exp("sw_memwr",  4'd5, 0,1,1,0,0,0,0,0, 2'b00, 2'b00, 3'b010, 0);

    // R-type sub
    start(6'b000000, 6'b100010);
    fetch("sub_fetch");
    decode("sub_decode", 0);
    exp("sub_exec", 4'd6, 0,0,0,0,0,0,0,1, 2'b00, 2'b00, 3'b110, 0);
    exp("sub_wb",   4'd7, 0,0,0,0,1,0,1,0, 2'b00, 2'b00, 3'b010, 0);

    for (int i = 0; i < 4; i++) begin
      start(6'b000000, fn_tab[i]);
      fetch("r_fetch");
      decode("r_decode", 0);
      exp("r_exec", 4'd6, 0,0,0,0,0,0,0,1, 2'b00, 2'b00, sel_tab[i], 0);
      exp("r_wb",   4'd7, 0,0,0,0,1,0,1,0, 2'b00, 2'b00, 3'b010, 0);
    end

    // beq taken, then not taken, then flag rising mid-BRANCH
    start(6'b000100, 6'b000000);
    ALU_Zero_Flag = 1'b1;
    fetch("beq1_fetch");
    decode("beq1_decode", 0);
    exp("beq1_branch", 4'd8, 1,0,0,0,0,0,0,1, 2'b00, 2'b01, 3'b110, 0);
    ALU_Zero_Flag = 1'b0;
    fetch("beq0_fetch");
    decode("beq0_decode", 0);
    exp("beq0_branch", 4'd8, 0,0,0,0,0,0,0,1, 2'b00, 2'b01, 3'b110, 0);
    fetch("beqm_fetch");
    decode("beqm_decode", 0);
    #2 ALU_Zero_Flag = 1'b1;
    exp("beq_mealy", 4'd8, 1,0,0,0,0,0,0,1, 2'b00, 2'b01, 3'b110, 0);
    ALU_Zero_Flag = 1'b0;

    // addi and lui
    start(6'b001000, 6'b000000);
    fetch("addi_fetch");
    decode("addi_decode", 0);
    exp("addi_exec", 4'd9,  0,0,0,0,0,0,0,1, 2'b10, 2'b00, 3'b010, 0);
    exp("addi_wb",   4'd10, 0,0,0,0,0,0,1,0, 2'b00, 2'b00, 3'b010, 0);
    start(6'b001111, 6'b000000);
    fetch("lui_fetch");
    decode("lui_decode", 0);
    exp("lui_exec", 4'd9,  0,0,0,0,0,0,0,1, 2'b10, 2'b00, 3'b100, 0);
    exp("lui_wb",   4'd10, 0,0,0,0,0,0,1,0, 2'b00, 2'b00, 3'b010, 0);

    // j
    start(6'b000010, 6'b000000);
    fetch("j_fetch");
    decode("j_decode", 0);
    exp("j_jump", 4'd11, 1,0,0,0,0,0,0,0, 2'b00, 2'b10, 3'b010, 0);

    // illegal opcode: 2-cycle round trip
    start(6'b111111, 6'b000000);
    fetch("illop_fetch");
    decode("illop_decode", 1);

    // illegal funct
    start(6'b000000, 6'b111111);
    fetch("illfn_fetch");
    decode("illfn_decode", 0);
    exp("illfn_exec", 4'd6, 0,0,0,0,0,0,0,1, 2'b00, 2'b00, 3'b010, 1);

    // funct 000100
    start(6'b000000, 6'b000100);
    fetch("sllv_fetch");
    decode("sllv_decode", 0);
`ifdef MIPS_SLLV_EN
    exp("sllv_exec", 4'd6, 0,0,0,0,0,0,0,1, 2'b00, 2'b00, 3'b011, 0);
    exp("sllv_wb",   4'd7, 0,0,0,0,1,0,1,0, 2'b00, 2'b00, 3'b010, 0);
`else
    exp("sllv_exec", 4'd6, 0,0,0,0,0,0,0,1, 2'b00, 2'b00, 3'b010, 1);
`endif

    // reset in the middle of lw (entering MEM_READ)
    start(6'b100011, 6'b000000);
    fetch("rstm_fetch");
    decode("rstm_decode", 0);
    exp("rstm_memadr", 4'd2, 0,0,0,0,0,0,0,1, 2'b10, 2'b00, 3'b010, 0);
    RST = 1'b1;
    exp("rstm_memrd", 4'd3, 0,1,0,0,0,0,0,0, 2'b00, 2'b00, 3'b010, 0);
    exp("rstm_held",  4'd0, 0,0,0,0,0,0,0,0, 2'b01, 2'b00, 3'b010, 0);
    RST = 1'b0;
    fetch("rstm_release");
    decode("rstm_redecode", 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
